// File: rtl/huff_pkg.sv
// Shared Huffman definitions: symbol numbering, code payload and code table.
package huff_pkg;

  localparam int unsigned SYM_W  = 3;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned LEN_W  = 3;

  // Symbol numbering shared by encoder, decoder and benches
  typedef enum logic [SYM_W-1:0] {
    SYM_NULL = 3'd0,
    SYM_A    = 3'd1,
    SYM_B    = 3'd2,
    SYM_C    = 3'd3,
    SYM_D    = 3'd4,
    SYM_E    = 3'd5,
    SYM_F    = 3'd6,
    SYM_BAD  = 3'd7
  } huff_sym_t;

  // Codeword right-aligned in code, number of valid bits in len
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
  } huff_code_t;

  // Prefix code table; unused symbols map to an empty code
  function automatic huff_code_t huff_lookup(input logic [SYM_W-1:0] sym);
    huff_code_t r;
    r = '{code: 4'b0000, len: 3'd0};
    case (sym)
      SYM_A:   r = '{code: 4'b0000, len: 3'd1};
      SYM_B:   r = '{code: 4'b0101, len: 3'd3};
      SYM_C:   r = '{code: 4'b0100, len: 3'd3};
      SYM_D:   r = '{code: 4'b0111, len: 3'd3};
      SYM_E:   r = '{code: 4'b1101, len: 3'd4};
      SYM_F:   r = '{code: 4'b1100, len: 3'd4};
      default: r = '{code: 4'b0000, len: 3'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/huff_sym_fifo.sv
// Small synchronous symbol FIFO; read data is the combinational head entry.
module huff_sym_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign full    = (r_count == (PTR_W+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;
  assign dout    = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally; count carries the extra bit to tell full from empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/huffman_encoder.sv
// Huffman encoder: buffers symbols and streams their prefix codes MSB-first.
module huffman_encoder
  import huff_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             x,
  output logic             x_valid,
  output logic             x_last,
  output logic             err
);

  logic             w_full;
  logic             w_empty;
  logic             w_sym_ok;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_busy;
  logic [SYM_W-1:0] w_head;
  huff_code_t       w_code;
  logic [CODE_W-1:0] w_aligned;

  logic [2:0]       r_sreg;
  logic [1:0]       r_rem;
  logic             r_x;
  logic             r_x_valid;
  logic             r_err;

  // Invalid symbols complete the handshake but never enter the FIFO
  assign sym_ready = !w_full;
  assign w_sym_ok  = (sym_in != SYM_NULL) && (sym_in != SYM_BAD);
  assign w_wr_en   = sym_valid && !w_full && w_sym_ok;

  // Pop only when the current codeword is on its final bit (or idle)
  assign w_busy    = r_x_valid && (r_rem != 2'd0);
  assign w_rd_en   = !w_busy && !w_empty;

  // Left-align the head codeword so its first bit sits in the MSB
  assign w_code    = huff_lookup(w_head);
  assign w_aligned = w_code.code << (3'd4 - w_code.len);

  huff_sym_fifo #(
    .WIDTH (SYM_W),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (w_wr_en),
    .rd_en (w_rd_en),
    .din   (sym_in),
    .full  (w_full),
    .empty (w_empty),
    .dout  (w_head)
  );

  // Serializer: shift out the current code, else load the next one, else idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x       <= 1'b0;
      r_x_valid <= 1'b0;
      r_sreg    <= 3'd0;
      r_rem     <= 2'd0;
    end else if (w_busy) begin
      r_x       <= r_sreg[2];
      r_sreg    <= {r_sreg[1:0], 1'b0};
      r_rem     <= r_rem - 2'd1;
      r_x_valid <= 1'b1;
    end else if (!w_empty) begin
      r_x       <= w_aligned[3];
      r_sreg    <= w_aligned[2:0];
      r_rem     <= 2'(w_code.len - 3'd1);
      r_x_valid <= 1'b1;
    end else begin
      r_x       <= 1'b0;
      r_x_valid <= 1'b0;
      r_rem     <= 2'd0;
    end
  end

  // Sticky flag for any accepted out-of-range symbol
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (sym_valid && !w_full && !w_sym_ok) begin
      r_err <= 1'b1;
    end
  end

  assign x       = r_x;
  assign x_valid = r_x_valid;
  assign x_last  = r_x_valid && (r_rem == 2'd0);
  assign err     = r_err;

endmodule
